// File: rtl/tile_pkg.sv
// Shared types and constants for the text-mode tile memory controller.
package tile_pkg;

    localparam int TILE_COLS = 40;
    localparam int TILE_ROWS = 30;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        OP_PUTC    = 2'b00,
        OP_SETCUR  = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_NEWLINE = 2'b11
    } cmd_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/tile_cursor.sv
// Hardware text cursor: column, row and the matching linear tile address.
// The linear address is kept in step incrementally so no multiplier is needed
// on the PUTC/NEWLINE path; SETCUR rebuilds it with a constant shift-add.
module tile_cursor #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          newline,
    input  logic          load,
    input  logic          home,
    input  logic [5:0]    load_col,
    input  logic [4:0]    load_row,
    output logic [5:0]    col,
    output logic [4:0]    row,
    output logic [AW-1:0] addr
);

    localparam logic [5:0]    LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(COLS);

    logic [5:0] sat_col;
    logic [4:0] sat_row;

    // row*COLS built from shifted copies of row for each set bit of COLS
    function automatic logic [AW-1:0] row_base(input logic [4:0] r);
        logic [AW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (COLS[i]) begin
                acc = acc + (AW'(r) << i);
            end
        end
        return acc;
    endfunction

    // Clamp requested position into the visible tile grid
    always_comb begin
        sat_col = (load_col > LAST_COL) ? LAST_COL : load_col;
        sat_row = (load_row > LAST_ROW) ? LAST_ROW : load_row;
    end

    // Cursor register: home/load/newline/advance, wrapping at the screen end
    always_ff @(posedge clk) begin
        if (rst || home) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (load) begin
            col  <= sat_col;
            row  <= sat_row;
            addr <= row_base(sat_row) + AW'(sat_col);
        end else if (newline) begin
            col <= '0;
            if (row == LAST_ROW) begin
                row  <= '0;
                addr <= '0;
            end else begin
                row  <= row + 5'd1;
                addr <= addr + ROW_STEP - AW'(col);
            end
        end else if (advance) begin
            if (col == LAST_COL) begin
                col <= '0;
                if (row == LAST_ROW) begin
                    row  <= '0;
                    addr <= '0;
                end else begin
                    row  <= row + 5'd1;
                    addr <= addr + AW'(1);
                end
            end else begin
                col  <= col + 6'd1;
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/tilemem_ctrl.sv
// Tile RAM arbiter: video fetch has absolute priority; host commands
// (PUTC/SETCUR/NEWLINE/CLEAR) use the port only in cycles without a fetch.
module tilemem_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = 11
) (
    input  logic          px_clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [7:0]    vid_char,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [10:0]   cmd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic [5:0]    cur_col,
    output logic [4:0]    cur_row
);

    import tile_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);

    state_t        state;
    state_t        state_next;
    cmd_op_t       op;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] cur_addr;
    logic          clr_step;
    logic          do_adv;
    logic          do_nl;
    logic          do_load;
    logic          do_home;

    assign op       = cmd_op_t'(cmd_op);
    assign busy     = (state == ST_CLEAR);
    assign vid_char = mem_rdata;

    tile_cursor #(
        .COLS(COLS),
        .ROWS(ROWS),
        .AW  (AW)
    ) u_cursor (
        .clk     (px_clk),
        .rst     (rst),
        .advance (do_adv),
        .newline (do_nl),
        .load    (do_load),
        .home    (do_home),
        .load_col(cmd_data[5:0]),
        .load_row(cmd_data[10:6]),
        .col     (cur_col),
        .row     (cur_row),
        .addr    (cur_addr)
    );

    // Arbitration, command decode and CLEAR sequencing
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        mem_addr   = cur_addr;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        clr_step   = 1'b0;
        do_adv     = 1'b0;
        do_nl      = 1'b0;
        do_load    = 1'b0;
        do_home    = 1'b0;
        if (vid_req) begin
            mem_addr = vid_addr;
        end
        case (state)
            ST_IDLE: begin
                cmd_ready = !rst && !vid_req;
                if (cmd_valid && cmd_ready) begin
                    case (op)
                        OP_PUTC: begin
                            mem_we    = 1'b1;
                            mem_wdata = cmd_data[7:0];
                            do_adv    = 1'b1;
                        end
                        OP_SETCUR:  do_load    = 1'b1;
                        OP_NEWLINE: do_nl      = 1'b1;
                        OP_CLEAR:   state_next = ST_CLEAR;
                    endcase
                end
            end
            ST_CLEAR: begin
                // reset must abort without a stray write in its own cycle
                if (!vid_req && !rst) begin
                    mem_addr  = clr_addr;
                    mem_we    = 1'b1;
                    mem_wdata = CHAR_SPACE;
                    clr_step  = 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state_next = ST_IDLE;
                        do_home    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge px_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear address counter, parked at zero whenever idle
    always_ff @(posedge px_clk) begin
        if (rst || state == ST_IDLE) begin
            clr_addr <= '0;
        end else if (clr_step) begin
            clr_addr <= clr_addr + AW'(1);
        end
    end

    // Video fetch result is valid one cycle after the request
    always_ff @(posedge px_clk) begin
        if (rst) begin
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_req;
        end
    end

endmodule

// File: doc/tilemem_ctrl.md
# tilemem_ctrl

Arbiter and command sequencer for the single-port text-mode tile memory (40×30 tiles of 8×8 px at zoom 1). It shares the memory between the VGA scan fetch, which has absolute priority, and a host command port that writes characters at a hardware cursor, moves the cursor, issues newlines and clears the screen. It sits between `vga_sync`/`font` and the tile RAM, in the `px_clk` domain.

## Interface
Parameters:
- `COLS`, 40, tiles per row
- `ROWS`, 30, tile rows
- `AW`, 11, tile address width (must hold COLS*ROWS-1)

Ports:
- `px_clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `vid_req`  in  1  video fetch needed this cycle
- `vid_addr`  in  AW  linear tile address to fetch
- `vid_valid`  out  1  `mem_rdata` holds the video fetch result
- `vid_char`  out  8  character code for video (= `mem_rdata`)
- `cmd_valid`  in  1  host command present
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 PUTC, 01 SETCUR, 10 CLEAR, 11 NEWLINE
- `cmd_data`  in  11  PUTC: [7:0] char; SETCUR: [5:0] col, [10:6] row
- `mem_addr`  out  AW  tile RAM address
- `mem_we`  out  1  tile RAM write enable
- `mem_wdata`  out  8  tile RAM write data
- `mem_rdata`  in  8  tile RAM read data, one-cycle synchronous read
- `busy`  out  1  CLEAR in progress
- `cur_col`  out  6  cursor column
- `cur_row`  out  5  cursor row

## Operation
- Ports are combinational in `vid_req`. If `vid_req`=1: `mem_addr`=`vid_addr`, `mem_we`=0. No host or clear access occurs in that cycle.
- FSM states:
  - IDLE: `cmd_ready` = `!vid_req`.
  - CLEAR: `cmd_ready`=0.
- PUTC (accepted): `mem_we`=1, `mem_addr`=cursor linear address, `mem_wdata`=char in the same cycle. The cursor then advances.
- Cursor advance:
  - col+1.
  - At col=COLS-1: col=0, row+1.
  - At row=ROWS-1 and col=COLS-1: wrap to (0,0). There is no scrolling.
- NEWLINE: col=0, row+1. Row wraps ROWS-1→0. No memory access.
- SETCUR: col and row saturate to COLS-1 and ROWS-1. The linear address is recomputed as row*COLS+col using shift-add (row<<5 + row<<3 for 40). No multiplier.
- The linear cursor address register is maintained incrementally on PUTC and NEWLINE. It always equals row*COLS+col.
- CLEAR (accepted): go to CLEAR with `clr_addr`=0.
  - Each cycle with `vid_req`=0: write 8'h20 to `clr_addr`, then increment.
  - Cycles with `vid_req`=1 stall.
  - After writing COLS*ROWS-1: cursor=(0,0), return to IDLE.

## Timing
- Reset values:
  - state IDLE
  - cursor (0,0), linear address 0, `clr_addr` 0
  - `vid_valid`=0, `busy`=0
  - `cmd_ready`=0 while `rst`=1
- Video fetch latency: 1 cycle. `vid_valid` is `vid_req` registered. `vid_char` is valid when `vid_valid`=1.
- Command effects:
  - PUTC write is in the acceptance cycle. The new cursor is visible the next cycle.
  - SETCUR and NEWLINE update the cursor the next cycle.
- CLEAR timing:
  - `busy`=1 from the cycle after acceptance through the final write cycle. IDLE and `cmd_ready` return the following cycle.
  - Duration = COLS*ROWS + number of `vid_req`=1 cycles during CLEAR.
- Simultaneous `vid_req` and `cmd_valid`: video wins and the command is held. The host must keep `cmd_valid` and the payload stable until accepted.
- Reset mid-CLEAR: aborts immediately. Partially cleared contents remain in RAM.

## Structure
- Package `tile_pkg`: `cmd_op` enum (OP_PUTC, OP_SETCUR, OP_CLEAR, OP_NEWLINE), FSM state enum, `TILE_COLS`=40, `TILE_ROWS`=30, `CHAR_SPACE`=8'h20.
- Sub-module `tile_cursor`: holds col, row and the linear address. Inputs advance, newline, load(col,row) and home. This keeps wrap/saturate logic separately testable.
- Top: arbitration mux, CLEAR FSM and counter, `vid_valid` register.

## Test plan
- Reset, then PUTC 'A' (8'h41) with `vid_req`=0 → `mem_we`=1, addr 0, data 8'h41 the same cycle; next cycle cursor=(1,0).
- SETCUR col=39 row=29, then PUTC → write at addr 1199; cursor wraps to (0,0).
- SETCUR col=50 row=31 → cursor saturates to (39,29), address 1199. NEWLINE from (5,29) → (0,0).
- `vid_req`=1 with `cmd_valid`=1 for 3 cycles → `cmd_ready`=0, no writes, `mem_addr`=`vid_addr`; `vid_valid` is high 1 cycle after each `vid_req`.
- CLEAR with `vid_req` asserted in 100 scattered cycles → exactly 1200 writes of 8'h20 to addresses 0..1199; `busy` spans 1300 cycles; cursor (0,0) after.
- `rst` asserted at `clr_addr`=600 → next cycle IDLE, `busy`=0, cursor (0,0); addresses ≥600 untouched.
